sha256_compress: RTL and testbench

SHA-256 compression engine; the consumer end of the message-schedule (W memory) stream. Presents the round index `I` to the schedule block, takes one 32-bit `W[i]` per cycle, runs the 64 rounds over working variables a..h, then folds the result into the chaining hash `H0..H7`. Multi-block messages are hashed by issuing successive `START`s without `INIT`; the digest is read from `DIGEST` on `DONE`.

---
 rtl/sha256_pkg.sv | 48 ++++
 rtl/sha256_k_rom.sv | 22 ++
 rtl/sha256_compress.sv | 114 +++++++++++
 tb/tb_sha256_compress.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: IVs, compression FSM encoding and the FIPS 180-4 logic functions.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // H0 sits in bits 255:224, matching the DIGEST layout.
  localparam logic [255:0] IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  // Message-schedule sigmas, kept here so the schedule block can share them.
  function automatic word_t small_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant ROM: round index -> K[idx].
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0] idx,
  output word_t      k
);

  localparam word_t K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  assign k = K_TABLE[idx];

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: 64 rounds per block, one W word per cycle, chaining hash in H0..H7.
// Define SHA256_COMPRESS_SHA224_EN to add MODE_224, which selects the SHA-224 IV on INIT.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic         INIT,
`ifdef SHA256_COMPRESS_SHA224_EN
  input  logic         MODE_224,
`endif
  input  logic [31:0]  W_IN,
  output logic [5:0]   I,
  output logic         BUSY,
  output logic         DONE,
  output logic [255:0] DIGEST
);

  state_t       state_reg, state_next;
  logic [5:0]   idx_reg, idx_next;
  word_t        h_reg [8];
  word_t        h_next [8];
  word_t        wv_reg [8];   // index 0 = a ... index 7 = h
  word_t        wv_next [8];
  logic         busy_reg, busy_next;
  logic         done_reg, done_next;
  logic [255:0] iv_sel;
  word_t        k_word, t1, t2;

`ifdef SHA256_COMPRESS_SHA224_EN
  assign iv_sel = MODE_224 ? IV_224 : IV_256;
`else
  assign iv_sel = IV_256;
`endif

  sha256_k_rom u_k_rom (
    .idx (idx_reg),
    .k   (k_word)
  );

  assign t1 = wv_reg[7] + big_sigma1(wv_reg[4]) + ch(wv_reg[4], wv_reg[5], wv_reg[6]) + k_word + W_IN;
  assign t2 = big_sigma0(wv_reg[0]) + maj(wv_reg[0], wv_reg[1], wv_reg[2]);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    for (int k = 0; k < 8; k++) begin
      h_next[k]  = h_reg[k];
      wv_next[k] = wv_reg[k];
    end
    case (state_reg)
      ST_IDLE: begin
        if (START) begin
          // INIT in the same cycle seeds both H and the working set with the IV.
          for (int k = 0; k < 8; k++) begin
            h_next[k]  = INIT ? iv_sel[255-32*k -: 32] : h_reg[k];
            wv_next[k] = h_next[k];
          end
          idx_next   = '0;
          state_next = ST_ROUND;
        end else if (INIT) begin
          for (int k = 0; k < 8; k++) h_next[k] = iv_sel[255-32*k -: 32];
        end
      end
      ST_ROUND: begin
        wv_next[0] = t1 + t2;
        for (int k = 1; k < 8; k++) wv_next[k] = wv_reg[k-1];
        wv_next[4] = wv_reg[3] + t1;
        if (idx_reg == 6'd63) state_next = ST_FINAL;
        else                  idx_next   = idx_reg + 6'd1;
      end
      ST_FINAL: begin
        for (int k = 0; k < 8; k++) h_next[k] = h_reg[k] + wv_reg[k];
        idx_next   = '0;
        state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign busy_next = (state_next == ST_ROUND) || (state_next == ST_FINAL);
  assign done_next = (state_next == ST_DONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        h_reg[k]  <= IV_256[255-32*k -: 32];
        wv_reg[k] <= '0;
      end
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      h_reg     <= h_next;
      wv_reg    <= wv_next;
    end
  end

  assign I    = idx_reg;
  assign BUSY = busy_reg;
  assign DONE = done_reg;

  for (genvar gi = 0; gi < 8; gi++) begin : g_digest
    assign DIGEST[255-32*gi -: 32] = h_reg[gi];
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Bench for sha256_compress: loop-based SHA-256 reference model, per-cycle compare, known-answer digests.
module tb_sha256_compress;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         init = 1'b0;
  logic [31:0]  w_in = '0;
  logic [5:0]   i_out;
  logic         busy, done;
  logic [255:0] digest;
`ifdef SHA256_COMPRESS_SHA224_EN
  logic         mode_224 = 1'b0;
`endif

  sha256_compress dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .START    (start),
    .INIT     (init),
`ifdef SHA256_COMPRESS_SHA224_EN
    .MODE_224 (mode_224),
`endif
    .W_IN     (w_in),
    .I        (i_out),
    .BUSY     (busy),
    .DONE     (done),
    .DIGEST   (digest)
  );

  initial forever #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;

  logic [31:0] kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [31:0] iv256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] iv224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                             32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [255:0] DIG_IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic [31:0] w_mem [64];

  // Reference model: m_k = cycles since the accepted START edge, -1 when idle.
  int          m_k = -1;
  logic [31:0] m_h [8];
  logic [31:0] m_res [8];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_block(input logic [511:0] blk);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w_mem[t] = blk[511-32*t -: 32];
      else w_mem[t] = (rotr(w_mem[t-2], 17) ^ rotr(w_mem[t-2], 19) ^ (w_mem[t-2] >> 10)) + w_mem[t-7]
                    + (rotr(w_mem[t-15], 7) ^ rotr(w_mem[t-15], 18) ^ (w_mem[t-15] >> 3)) + w_mem[t-16];
    end
  endtask

  task automatic load_iv();
    for (int j = 0; j < 8; j++) begin
`ifdef SHA256_COMPRESS_SHA224_EN
      m_h[j] = mode_224 ? iv224[j] : iv256[j];
`else
      m_h[j] = iv256[j];
`endif
    end
  endtask

  task automatic compute_res();
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    for (int j = 0; j < 8; j++) v[j] = m_h[j];
    for (int r = 0; r < 64; r++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
         + kt[r] + w_mem[r];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) m_res[j] = m_h[j] + v[j];
  endtask

  function automatic logic [255:0] model_digest();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[255-32*j -: 32] = m_h[j];
    return r;
  endfunction

  initial begin
    for (int j = 0; j < 8; j++) m_h[j] = iv256[j];
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_k = -1;
        for (int j = 0; j < 8; j++) m_h[j] = iv256[j];
      end else if (m_k < 0) begin
        if (start) begin
          if (init) load_iv();
          compute_res();
          m_k = 0;
        end else if (init) begin
          load_iv();
        end
      end else if (m_k == 64) begin
        for (int j = 0; j < 8; j++) m_h[j] = m_res[j];
        m_k = 65;
      end else if (m_k == 65) begin
        m_k = -1;
      end else begin
        m_k++;
      end
    end
  end

  // Schedule-block stand-in: presents W[I] on the falling edge.
  initial forever begin
    @(negedge clk);
    w_in = w_mem[i_out];
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    chk("cyc_busy", 256'(busy), 256'(m_k >= 0 && m_k <= 64));
    chk("cyc_done", 256'(done), 256'(m_k == 65));
    chk("cyc_i", 256'(i_out), 256'((m_k >= 0 && m_k <= 63) ? m_k : (m_k == 64 ? 63 : 0)));
    chk("cyc_digest", digest, model_digest());
  end

  // One block; DONE is expected after the 65th edge following the START edge.
  task automatic run_block(input bit do_init, input bit pulse, input bit check_lit,
                           input logic [255:0] lit, input string name);
    int n;
    @(negedge clk); #1;
    start = 1'b1;
    init  = do_init;
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 200) begin
      start = pulse && (n == 10 || n == 64);
      init  = start;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    init  = 1'b0;
    chk({name, "_latency"}, 256'(n), 256'(65));
    if (check_lit) chk({name, "_digest"}, digest, lit);
    $display("block %s: done after %0d edges, digest %h", name, n, digest);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_done", 256'(done), 256'(0));
    chk("reset_i", 256'(i_out), 256'(0));
    chk("reset_digest", digest, DIG_IV);
    rst_n = 1'b1;

    set_block({32'h80000000, 480'h0});
    run_block(1'b1, 1'b0, 1'b1, DIG_EMPTY, "empty");

    set_block({32'h61626380, 448'h0, 32'h00000018});
    run_block(1'b1, 1'b0, 1'b1, DIG_ABC, "abc");

    set_block({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
               32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000});
    run_block(1'b1, 1'b0, 1'b0, '0, "two_blk1");
    set_block({480'h0, 32'h000001c0});
    run_block(1'b0, 1'b0, 1'b1, DIG_TWO, "two_blk2");

    // INIT alone in IDLE, then START without INIT must hash from the IV.
    @(negedge clk); #1 init = 1'b1;
    @(posedge clk); #1 init = 1'b0;
    chk("init_only_digest", digest, DIG_IV);
    set_block({32'h61626380, 448'h0, 32'h00000018});
    run_block(1'b0, 1'b0, 1'b1, DIG_ABC, "abc_after_init");

    run_block(1'b1, 1'b1, 1'b1, DIG_ABC, "abc_pulsed");

    // Abort a block at round 30; the following block must start from the reset IV.
    @(negedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (i_out != 6'd30 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_round30", 256'(i_out), 256'(30));
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_done", 256'(done), 256'(0));
    chk("midrst_i", 256'(i_out), 256'(0));
    chk("midrst_digest", digest, DIG_IV);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_block(1'b0, 1'b0, 1'b1, DIG_ABC, "abc_after_reset");

`ifdef SHA256_COMPRESS_SHA224_EN
    mode_224 = 1'b1;
    run_block(1'b1, 1'b0, 1'b0, '0, "abc_224");
    chk("sha224_digest", 256'(digest[255:32]),
        256'(224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7));
    mode_224 = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
